// File: rtl/pic_cycle_sequencer.sv
// pic_cycle_sequencer
//   Single-clock instruction-cycle sequencer for the PIC core. Generates one-hot
//   phase enables, owns the program counter, an N-deep circular return stack and
//   the pipeline flush flag. Adds run/halt, stall, skip and branch control.
// Ports
//   master_clk   : system clock, all state updates on rising edge
//   reset        : asynchronous active-low reset
//   run          : 1 = execute cycles, 0 = halt at the next cycle boundary
//   stall        : freeze phase counter and suppress phase_en
//   load_pc      : branch/goto/call target select (commit edge only)
//   load_addr    : branch target
//   push         : call, push pc+1 (commit edge only)
//   pop          : return, next pc = stack top (commit edge only)
//   skip         : next instruction becomes a NOP (commit edge only)
//   phase_en     : one-hot phase enable, zero when idle, stalled or in reset
//   cycle_start  : phase_en[0]
//   pc           : address of the instruction in the current cycle
//   flush        : current cycle's instruction is discarded
//   stack_ovf    : sticky, push with stack full
//   stack_unf    : sticky, pop with stack empty
module pic_cycle_sequencer #(
  parameter int unsigned PHASES       = 4,
  parameter int unsigned PC_WIDTH     = 12,
  parameter int unsigned STACK_DEPTH  = 8,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic                master_clk,
  input  logic                reset,
  input  logic                run,
  input  logic                stall,
  input  logic                load_pc,
  input  logic [PC_WIDTH-1:0] load_addr,
  input  logic                push,
  input  logic                pop,
  input  logic                skip,
  output logic [PHASES-1:0]   phase_en,
  output logic                cycle_start,
  output logic [PC_WIDTH-1:0] pc,
  output logic                flush,
  output logic                stack_ovf,
  output logic                stack_unf
);

  localparam int unsigned PH_W  = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int unsigned SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned CNT_W = SP_W + 1;
  localparam logic [PH_W-1:0]  LAST_PH = PH_W'(PHASES - 1);
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(STACK_DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                flush_q, flush_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                stk_we;
  logic                pop_taken;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] stack_top;
  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];

  assign pc_inc    = pc_q + PC_WIDTH'(1);
  assign stack_top = stack_mem[sp_q - SP_W'(1)];
  assign pop_taken = pop && !push;

  // State register
  always_ff @(posedge master_clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      pc_q    <= PC_WIDTH'(RESET_VECTOR);
      sp_q    <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-stack storage; contents deliberately survive reset
  always_ff @(posedge master_clk) begin
    if (stk_we) begin
      stack_mem[sp_q] <= pc_inc;
    end
  end

  // Next-state: phase sequencing and commit-edge control
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    stk_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_RUN;
          phase_d = '0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (phase_q == LAST_PH) begin
            phase_d = '0;
            if (!run) begin
              state_d = S_IDLE;
            end
            pc_d    = pc_inc;
            flush_d = 1'b0;
            // A flushed cycle is a NOP: its control inputs are dropped
            if (!flush_q) begin
              if (push) begin
                stk_we = 1'b1;
                sp_d   = sp_q + SP_W'(1);
                if (cnt_q == FULL) begin
                  ovf_d = 1'b1;
                end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                end
              end else if (pop) begin
                sp_d = sp_q - SP_W'(1);
                if (cnt_q == '0) begin
                  unf_d = 1'b1;
                end else begin
                  cnt_d = cnt_q - CNT_W'(1);
                end
              end
              if (pop_taken) begin
                pc_d = stack_top;
              end else if (load_pc) begin
                pc_d = load_addr;
              end
              flush_d = pop_taken || load_pc || skip;
            end
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Phase decode; gated combinationally by stall so a stalled cycle shows no enable
  always_comb begin
    phase_en = '0;
    if (state_q == S_RUN && !stall) begin
      phase_en[phase_q] = 1'b1;
    end
  end

  assign cycle_start = phase_en[0];
  assign pc          = pc_q;
  assign flush       = flush_q;
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;

endmodule

// File: tb/tb_pic_cycle_sequencer.sv
// Self-checking bench for pic_cycle_sequencer: directed table, hand sequences
// for stack/skip/wrap/reset corners, then random stimulus against a cycle model.
module tb_pic_cycle_sequencer;

  localparam int unsigned PHASES = 4;
  localparam int unsigned PCW    = 12;
  localparam int unsigned DEPTH  = 8;

  logic            master_clk = 1'b0;
  logic            reset;
  logic            run, stall, load_pc, push, pop, skip;
  logic [PCW-1:0]  load_addr;
  logic [PHASES-1:0] phase_en;
  logic            cycle_start;
  logic [PCW-1:0]  pc;
  logic            flush, stack_ovf, stack_unf;

  pic_cycle_sequencer #(
    .PHASES(PHASES), .PC_WIDTH(PCW), .STACK_DEPTH(DEPTH), .RESET_VECTOR(0)
  ) dut (
    .master_clk (master_clk),
    .reset      (reset),
    .run        (run),
    .stall      (stall),
    .load_pc    (load_pc),
    .load_addr  (load_addr),
    .push       (push),
    .pop        (pop),
    .skip       (skip),
    .phase_en   (phase_en),
    .cycle_start(cycle_start),
    .pc         (pc),
    .flush      (flush),
    .stack_ovf  (stack_ovf),
    .stack_unf  (stack_unf)
  );

  always #5 master_clk = ~master_clk;

  typedef struct {
    bit             run;
    bit             stall;
    bit             ld;
    logic [PCW-1:0] addr;
    bit             push;
    bit             pop;
    bit             skip;
  } in_t;

  typedef struct {
    in_t             in;
    logic [PHASES-1:0] pe;
    logic [PCW-1:0]  pc;
    bit              fl;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state: running flag, phase index, pc, return-address queue
  bit m_run;
  int m_phase;
  int m_pc;
  bit m_pc_known;
  bit m_flush, m_ovf, m_unf;
  bit m_commit;
  int m_stk[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t ctl(bit ld, logic [PCW-1:0] addr, bit pu, bit po, bit sk);
    in_t v;
    v.run = 1'b1; v.stall = 1'b0; v.ld = ld; v.addr = addr;
    v.push = pu; v.pop = po; v.skip = sk;
    return v;
  endfunction

  function automatic vec_t mk(bit r, bit s, logic [PHASES-1:0] pe, logic [PCW-1:0] p, bit f);
    vec_t t;
    t.in = ctl(1'b0, '0, 1'b0, 1'b0, 1'b0);
    t.in.run = r; t.in.stall = s;
    t.pe = pe; t.pc = p; t.fl = f;
    return t;
  endfunction

  task automatic model_reset();
    m_run = 0; m_phase = 0; m_pc = 0; m_pc_known = 1;
    m_flush = 0; m_ovf = 0; m_unf = 0; m_commit = 0;
    m_stk.delete();
  endtask

  task automatic model_check(input in_t v);
    logic [PHASES-1:0] exp_pe;
    exp_pe = (m_run && !v.stall) ? PHASES'(1 << m_phase) : '0;
    check("phase_en", 32'(phase_en), 32'(exp_pe));
    check("cycle_start", 32'(cycle_start), 32'(exp_pe[0]));
    if (m_pc_known) check("pc", 32'(pc), 32'(m_pc));
    check("flush", 32'(flush), 32'(m_flush));
    check("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
    check("stack_unf", 32'(stack_unf), 32'(m_unf));
  endtask

  // One rising edge of the instruction-cycle rules
  task automatic model_step(input in_t v);
    int ret;
    bit took_pop;
    m_commit = 0;
    if (!m_run) begin
      if (v.run) begin m_run = 1; m_phase = 0; end
    end else if (!v.stall) begin
      if (m_phase == PHASES - 1) begin
        m_commit = 1;
        m_phase  = 0;
        if (!v.run) m_run = 0;
        ret = (m_pc + 1) % (1 << PCW);
        if (m_flush) begin
          m_pc = ret;
          m_flush = 0;
        end else begin
          took_pop = v.pop && !v.push;
          if (took_pop) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_unf = 1; m_pc_known = 0; end
          end else if (v.ld) m_pc = int'(v.addr);
          else m_pc = ret;
          if (v.push) begin
            if (m_stk.size() == DEPTH) begin
              m_ovf = 1;
              void'(m_stk.pop_front());
            end
            m_stk.push_back(ret);
          end
          m_flush = took_pop || v.ld || v.skip;
        end
      end else begin
        m_phase++;
      end
    end
  endtask

  task automatic apply(input in_t v);
    run = v.run; stall = v.stall; load_pc = v.ld; load_addr = v.addr;
    push = v.push; pop = v.pop; skip = v.skip;
  endtask

  task automatic tick(input in_t v);
    @(negedge master_clk);
    apply(v);
    #1;
    model_check(v);
    model_step(v);
  endtask

  // Run until the model's commit edge, controls held for the whole cycle
  task automatic instr(input in_t v);
    int n = 0;
    do begin
      tick(v);
      n++;
    end while (!m_commit && n < 2 * PHASES + 4);
    if (!m_commit) begin
      n_cmp++; n_err++;
      $display("FAIL instr_timeout: no commit after %0d cycles", n);
    end
  endtask

  // Observe state just after the commit edge
  task automatic post_check(input string name, input logic [PCW-1:0] exp_pc, input bit exp_fl);
    @(posedge master_clk);
    #1;
    check({name, "_pc"}, 32'(pc), 32'(exp_pc));
    check({name, "_flush"}, 32'(flush), 32'(exp_fl));
  endtask

  vec_t tbl[14];
  in_t  nop;
  in_t  rv;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nop = ctl(1'b0, '0, 1'b0, 1'b0, 1'b0);
    apply(nop);
    run = 1'b0;
    reset = 1'b0;
    model_reset();

    // Reset values
    @(negedge master_clk);
    #1;
    nop.run = 1'b0;
    model_check(nop);
    @(negedge master_clk);
    reset = 1'b1;

    // Start latency, phase stepping, stall in phase 2, halt at boundary
    tbl[0]  = mk(1, 0, 4'b0000, 12'h000, 0);
    tbl[1]  = mk(1, 0, 4'b0001, 12'h000, 0);
    tbl[2]  = mk(1, 0, 4'b0010, 12'h000, 0);
    tbl[3]  = mk(1, 0, 4'b0100, 12'h000, 0);
    tbl[4]  = mk(1, 0, 4'b1000, 12'h000, 0);
    tbl[5]  = mk(1, 0, 4'b0001, 12'h001, 0);
    tbl[6]  = mk(1, 0, 4'b0010, 12'h001, 0);
    tbl[7]  = mk(1, 1, 4'b0000, 12'h001, 0);
    tbl[8]  = mk(1, 1, 4'b0000, 12'h001, 0);
    tbl[9]  = mk(1, 1, 4'b0000, 12'h001, 0);
    tbl[10] = mk(0, 0, 4'b0100, 12'h001, 0);
    tbl[11] = mk(0, 0, 4'b1000, 12'h001, 0);
    tbl[12] = mk(0, 0, 4'b0000, 12'h002, 0);
    tbl[13] = mk(1, 0, 4'b0000, 12'h002, 0);
    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].in);
      check($sformatf("tbl%0d_pe", i), 32'(phase_en), 32'(tbl[i].pe));
      check($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].pc));
      check($sformatf("tbl%0d_fl", i), 32'(flush), 32'(tbl[i].fl));
    end

    // Call/return: pc 2 -> 5, call 0x123, then return to 0x006
    nop = ctl(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) instr(nop);
    post_check("to5", 12'h005, 1'b0);
    instr(ctl(1'b1, 12'h123, 1'b1, 1'b0, 1'b0));
    post_check("call", 12'h123, 1'b1);
    instr(nop);
    post_check("call_nop", 12'h124, 1'b0);
    instr(ctl(1'b0, '0, 1'b0, 1'b1, 1'b0));
    post_check("ret", 12'h006, 1'b1);
    instr(nop);
    post_check("ret_nop", 12'h007, 1'b0);

    // Nine pushes overflow, eight pops newest-first, ninth underflows
    for (int i = 0; i < 9; i++) begin
      instr(ctl(1'b0, '0, 1'b1, 1'b0, 1'b0));
      if (i == 7) begin
        @(posedge master_clk); #1;
        check("ovf_after8", 32'(stack_ovf), 32'd0);
      end
    end
    post_check("push9", 12'h010, 1'b0);
    check("ovf_after9", 32'(stack_ovf), 32'd1);
    for (int k = 0; k < 8; k++) begin
      instr(ctl(1'b0, '0, 1'b0, 1'b1, 1'b0));
      post_check($sformatf("pop%0d", k), 12'(16 - k), 1'b1);
      instr(nop);
    end
    check("unf_before9", 32'(stack_unf), 32'd0);
    instr(ctl(1'b0, '0, 1'b0, 1'b1, 1'b0));
    // Circular wrap lands on slot 0, last written by the ninth push (0x010)
    post_check("pop9", 12'h010, 1'b1);
    check("unf_after9", 32'(stack_unf), 32'd1);
    m_pc = 16;
    m_pc_known = 1;

    // Skip: 0x011 is a NOP whose load_pc is ignored
    instr(nop);
    instr(ctl(1'b1, 12'h00F, 1'b0, 1'b0, 1'b0));
    instr(nop);
    post_check("at10", 12'h010, 1'b0);
    instr(ctl(1'b0, '0, 1'b0, 1'b0, 1'b1));
    post_check("skip", 12'h011, 1'b1);
    instr(ctl(1'b1, 12'h3AB, 1'b0, 1'b0, 1'b0));
    post_check("skipped", 12'h012, 1'b0);

    // PC wrap at all-ones
    instr(ctl(1'b1, 12'hFFE, 1'b0, 1'b0, 1'b0));
    instr(nop);
    post_check("atFFF", 12'hFFF, 1'b0);
    instr(nop);
    post_check("wrap", 12'h000, 1'b0);

    // Async reset mid-phase with flush and sticky flags set
    instr(ctl(1'b1, 12'h055, 1'b0, 1'b0, 1'b0));
    tick(nop);
    tick(nop);
    @(posedge master_clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_pe", 32'(phase_en), 32'd0);
    check("rst_cs", 32'(cycle_start), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_ovf", 32'(stack_ovf), 32'd0);
    check("rst_unf", 32'(stack_unf), 32'd0);
    model_reset();
    @(posedge master_clk);
    #1;
    check("rst_hold_pc", 32'(pc), 32'd0);
    @(negedge master_clk);
    reset = 1'b1;

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      rv.run   = ($urandom % 10) != 0;
      rv.stall = ($urandom % 5) == 0;
      rv.ld    = ($urandom % 7) == 0;
      rv.addr  = PCW'($urandom);
      rv.push  = ($urandom % 7) == 0;
      rv.pop   = (m_stk.size() > 0) && (($urandom % 4) == 0);
      rv.skip  = ($urandom % 8) == 0;
      tick(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
